univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register, the successor to the single-bit D flip-flop in the flip-flop chapter. It is a WIDTH-bit register bank with a clock enable, synchronous clear, parallel load, logical and arithmetic shifts, and rotates. It exposes true and complement outputs plus serial outputs. It is the storage primitive for the counter, serial-link and shift-based multiplier blocks that follow.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 1..64
- RESET_VAL, {WIDTH{1'b0}}, value loaded on reset and by CLR mode

Ports:
- c  input  1  clock; all state changes occur on the rising edge
- rs  input  1  reset, synchronous, active-high
- en  input  1  clock enable; when 0 the register holds regardless of mode
- mode  input  3  operation select (encodings below)
- d  input  WIDTH  parallel load data
- sin_lsb  input  1  serial input entering bit 0 on shift-left
- sin_msb  input  1  serial input entering bit WIDTH-1 on logical shift-right
- q  output  WIDTH  register contents
- qb  output  WIDTH  bitwise complement of q, combinational (~q)
- sol  output  1  serial out, left: q[WIDTH-1], combinational
- sor  output  1  serial out, right: q[0], combinational

## Operation
- Priority at each rising edge of c: rs, then en, then mode.
- rs=1: q <= RESET_VAL; en and mode are ignored.
- rs=0, en=0: q holds.
- rs=0, en=1: q is updated according to mode:
  - 3'b000 HOLD: q <= q
  - 3'b001 SHL: q <= {q[W-2:0], sin_lsb}
  - 3'b010 SHR: q <= {sin_msb, q[W-1:1]}
  - 3'b011 ROL: q <= {q[W-2:0], q[W-1]}
  - 3'b100 ROR: q <= {q[0], q[W-1:1]}
  - 3'b101 LOAD: q <= d
  - 3'b110 ASR: q <= {q[W-1], q[W-1:1]}
  - 3'b111 CLR: q <= RESET_VAL
- WIDTH=1 boundary cases: SHL gives q <= sin_lsb; SHR gives q <= sin_msb; ROL, ROR and ASR hold.
- X or Z on d or on the serial inputs is not sanitised; it propagates into q.
- Every output is derived from q, so qb, sol and sor track q with no extra state.

## Timing
- Latency is one cycle from the input sampled at an edge to the new q.
- qb, sol and sor are combinational from q. They are valid in the same cycle as q, with no added register stage.
- Reset values: q=RESET_VAL, qb=~RESET_VAL, sol=RESET_VAL[W-1], sor=RESET_VAL[0].
- Reset asserted mid-sequence (for example during a burst of shifts) takes effect on the next edge. The sequence resumes from RESET_VAL once rs=0.
- Before the first edge with rs=1, q is undefined. The bench must apply rs for at least one edge.
- Inputs must be stable across the rising edge of c. No behaviour is defined between edges.

## Structure
- Package usr_pkg holds the mode localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_ASR, MODE_CLR.
- Sub-module usr_bit is the one-bit storage cell. It has an 8:1 next-value select driven by mode and its neighbours' q, a synchronous rs, and en. The top level instantiates WIDTH of these in a generate loop. End-of-chain neighbours are tied to sin_lsb, sin_msb, or the wrap bit as the mode requires.
- No other sub-modules.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=0x00.
1. Reset priority: rs=1, en=1, mode=LOAD, d=0xA5 → after the edge q=0x00, qb=0xFF, sol=0, sor=0.
2. Load and shift: LOAD 0xA5, then SHL with sin_lsb=1 → q=0xA5 (sol=1), then q=0x4B. Then SHR with sin_msb=0 → q=0x25.
3. Rotates: LOAD 0x81, ROL → 0x03; ROR → 0x81; ROR → 0xC0. No bits are lost over 8 consecutive ROLs, ending at 0xC0.
4. Arithmetic shift: LOAD 0x90, ASR → 0xC8, ASR → 0xE4. LOAD 0x40, ASR → 0x20 (sign bit 0 is preserved).
5. Enable and clear: LOAD 0x3C, then en=0 with mode=CLR for 3 cycles → q stays 0x3C. Then en=1, mode=CLR → 0x00.
6. Reset mid-operation: run SHL for 4 cycles with sin_lsb=1 from 0x00 → 0x0F. Assert rs for 1 cycle → 0x00. Continue SHL → 0x01.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register and its bit cell.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_bit.sv
// One storage bit of the universal shift register: 8:1 next-value select,
// synchronous reset to RST_BIT, clock enable.
module usr_bit
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       c,
  input  logic       rs,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       d,
  input  logic       lo_shift,  // value arriving from below on SHL
  input  logic       lo_rot,    // value arriving from below on ROL
  input  logic       hi_shift,  // value arriving from above on SHR
  input  logic       hi_rot,    // value arriving from above on ROR
  input  logic       hi_asr,    // value arriving from above on ASR
  output logic       q
);

  logic q_next;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL:  q_next = lo_shift;
      MODE_SHR:  q_next = hi_shift;
      MODE_ROL:  q_next = lo_rot;
      MODE_ROR:  q_next = hi_rot;
      MODE_LOAD: q_next = d;
      MODE_ASR:  q_next = hi_asr;
      MODE_CLR:  q_next = RST_BIT;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge c) begin
    if (rs)      q <= RST_BIT;
    else if (en) q <= q_next;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register built from usr_bit cells; the generate
// loop wires each cell to its neighbours and ties chain ends to serial/wrap bits.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             c,
  input  logic             rs,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sol,
  output logic             sor
);

  logic [WIDTH-1:0] lo_shift;
  logic [WIDTH-1:0] lo_rot;
  logic [WIDTH-1:0] hi_shift;
  logic [WIDTH-1:0] hi_rot;
  logic [WIDTH-1:0] hi_asr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // With WIDTH=1 both ends coincide, so ROL/ROR/ASR see q[0] and hold.
    if (i == 0) begin : g_lsb
      assign lo_shift[i] = sin_lsb;
      assign lo_rot[i]   = q[WIDTH-1];
    end else begin : g_lo
      assign lo_shift[i] = q[i-1];
      assign lo_rot[i]   = q[i-1];
    end

    if (i == WIDTH-1) begin : g_msb
      assign hi_shift[i] = sin_msb;
      assign hi_rot[i]   = q[0];
      assign hi_asr[i]   = q[WIDTH-1];
    end else begin : g_hi
      assign hi_shift[i] = q[i+1];
      assign hi_rot[i]   = q[i+1];
      assign hi_asr[i]   = q[i+1];
    end

    usr_bit #(
      .RST_BIT (RESET_VAL[i])
    ) u_bit (
      .c        (c),
      .rs       (rs),
      .en       (en),
      .mode     (mode),
      .d        (d[i]),
      .lo_shift (lo_shift[i]),
      .lo_rot   (lo_rot[i]),
      .hi_shift (hi_shift[i]),
      .hi_rot   (hi_rot[i]),
      .hi_asr   (hi_asr[i]),
      .q        (q[i])
    );
  end

  assign qb  = ~q;
  assign sol = q[WIDTH-1];
  assign sor = q[0];

endmodule
